// File: rtl/counter_down_4bit.sv
// Loadable down counter/timer: a ripple chain of half-subtractor cells computes q-1,
// and a three-state controller handles run, stop-at-zero and auto-reload.
`timescale 1ns/1ps
module counter_down_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] dec_s;
  logic [WIDTH:0]   bin_s;
  logic             run_s;

  // half-subtractor ripple chain; the final borrow-out is high exactly when count is zero
  always_comb begin
    bin_s[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      dec_s[i]     = count_q[i] ^ bin_s[i];
      bin_s[i + 1] = ~count_q[i] & bin_s[i];
    end
  end

  assign run_s  = (state_q == S_RUN);
  assign borrow = bin_s[WIDTH] & run_s & en;

  // next-state, next-count and terminal-count decode
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (load) begin
          count_d  = din;
          reload_d = din;
          state_d  = S_RUN;
        end else if (state_q == S_DONE) begin
          count_d = '0;
        end else begin
          count_d = count_q;
        end
      end
      S_RUN: begin
        if (load) begin
          count_d  = din;
          reload_d = din;
        end else if (en && !bin_s[WIDTH]) begin
          count_d = dec_s;
          tc_d    = (count_q == ONE_C);
        end else if (en) begin
          if (auto_reload) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = S_DONE;
          end
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
      end
    endcase
  end

  // state, count, reload and tc registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign q    = count_q;
  assign tc   = tc_q;
  assign busy = run_s;
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_counter_down_4bit.sv
// Scoreboard bench for counter_down_4bit: the driver queues hand-computed expectations
// per cycle, and a monitor pops and compares them against the sampled outputs.
`timescale 1ns/1ps
module tb_counter_down_4bit;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       busy;
    logic       done;
    logic       borrow;
    logic [7:0] id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] din;
  logic       en;
  logic       auto_reload;
  logic [3:0] q;
  logic       tc;
  logic       borrow;
  logic       busy;
  logic       done;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  logic [7:0] step_id = 8'd0;

  counter_down_4bit #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .din         (din),
    .en          (en),
    .auto_reload (auto_reload),
    .q           (q),
    .tc          (tc),
    .borrow      (borrow),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] id, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
  endtask

  // drive one cycle of inputs and queue the expected outcome of the next rising edge
  task automatic step(input logic ld, input logic [3:0] d, input logic e, input logic ar,
                      input logic [3:0] xq, input logic xtc, input logic xbusy,
                      input logic xdone, input logic xborrow);
    exp_t r;
    @(negedge clk);
    load = ld; din = d; en = e; auto_reload = ar;
    step_id = step_id + 8'd1;
    r.q = xq; r.tc = xtc; r.busy = xbusy; r.done = xdone; r.borrow = xborrow; r.id = step_id;
    sb.push_back(r);
  endtask

  // monitor: borrow is sampled before the edge, registered outputs just after it
  initial begin
    exp_t e;
    logic b;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        b = borrow;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("borrow", e.id, {7'd0, b},    {7'd0, e.borrow});
        chk("q",      e.id, {4'd0, q},    {4'd0, e.q});
        chk("tc",     e.id, {7'd0, tc},   {7'd0, e.tc});
        chk("busy",   e.id, {7'd0, busy}, {7'd0, e.busy});
        chk("done",   e.id, {7'd0, done}, {7'd0, e.done});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1; load = 1'b0; din = 4'd0; en = 1'b0; auto_reload = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_q",    8'd0, {4'd0, q},    8'd0);
    chk("rst_tc",   8'd0, {7'd0, tc},   8'd0);
    chk("rst_busy", 8'd0, {7'd0, busy}, 8'd0);
    chk("rst_done", 8'd0, {7'd0, done}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle: en ignored
    for (int i = 0; i < 5; i++) step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // one-shot from 3
    step(1'b1, 4'd3, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // auto-reload from 2, load wins over en
    step(1'b1, 4'd2, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 3; p++) begin
      if (p > 0) step(1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // enable gaps and load priority
    step(1'b1, 4'd15, 1'b0, 1'b0, 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0,  1'b1, 1'b0, 4'd14, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0,  1'b0, 1'b0, 4'd14, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0,  1'b1, 1'b0, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0,  1'b0, 1'b0, 4'd13, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd5,  1'b1, 1'b0, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'd5,  1'b0, 1'b0, 4'd5,  1'b0, 1'b1, 1'b0, 1'b0);

    // reload value 0: stuck at zero, borrow on every enabled cycle, no tc
    step(1'b1, 4'd0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    // load 1: tc after the first enable, then stop
    step(1'b1, 4'd1, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // reset mid-count aborts immediately
    step(1'b1, 4'd7, 1'b0, 1'b0, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    load = 1'b0; en = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_q",      8'd0, {4'd0, q},            8'd0);
    chk("arst_tc",     8'd0, {7'd0, tc},           8'd0);
    chk("arst_busy",   8'd0, {7'd0, busy},         8'd0);
    chk("arst_done",   8'd0, {7'd0, done},         8'd0);
    chk("arst_reload", 8'd0, {4'd0, dut.reload_q}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) step(1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 8'd0, 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
